// File: rtl/micro_sequencer_if.sv
// Control-unit side bundle for the microprogram sequencer: the microinstruction
// next-address fields and ALU flags in, the control-store address and status out.
interface micro_sequencer_if #(
  parameter int AW    = 8,
  parameter int OPW   = 4,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic           stall;
  logic [2:0]     na_sel;
  logic [2:0]     bs;
  logic [AW-1:0]  target;
  logic [OPW-1:0] opcode;
  logic           fl_ld;
  logic           z_in;
  logic           n_in;
  logic [AW-1:0]  upc;
  logic           z_q;
  logic           n_q;
  logic [SPW-1:0] sp;
  logic           err;

  // master: the control unit driving microinstruction fields
  modport master (
    output stall, na_sel, bs, target, opcode, fl_ld, z_in, n_in,
    input  upc, z_q, n_q, sp, err
  );

  // slave: the sequencer itself
  modport slave (
    input  stall, na_sel, bs, target, opcode, fl_ld, z_in, n_in,
    output upc, z_q, n_q, sp, err
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: registered uPC with seq/jump/cond/map/call/ret/fetch
// next-address selection, latched Z/N flags and a small return-address stack.
module micro_sequencer #(
  parameter int            AW         = 8,
  parameter int            OPW        = 4,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] MAP_BASE   = 8'h40,
  parameter logic [AW-1:0] FETCH_ADDR = '0
) (
  input logic              clk,
  input logic              rst_n,
  micro_sequencer_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [2:0] NA_SEQ   = 3'b000;
  localparam logic [2:0] NA_JUMP  = 3'b001;
  localparam logic [2:0] NA_COND  = 3'b010;
  localparam logic [2:0] NA_MAP   = 3'b011;
  localparam logic [2:0] NA_CALL  = 3'b100;
  localparam logic [2:0] NA_RET   = 3'b101;
  localparam logic [2:0] NA_FETCH = 3'b110;

  logic [AW-1:0]  upc_q, upc_d;
  logic           z_q, z_d;
  logic           n_q, n_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];

  logic [AW-1:0]  upc_inc;
  logic [AW-1:0]  map_addr;
  logic [AW-1:0]  stack_top;
  logic [SPW-1:0] top_idx;
  logic           cond;
  logic           push;

  assign upc_inc  = upc_q + AW'(1);
  assign map_addr = MAP_BASE + AW'({bus.opcode, 2'b00});
  assign top_idx  = sp_q - SPW'(1);

  // Condition looks only at the latched flags, never at z_in/n_in.
  always_comb begin
    cond = 1'b0;
    case (bus.bs)
      3'b000:  cond = z_q;
      3'b001:  cond = ~z_q;
      3'b010:  cond = ~n_q;
      3'b011:  cond = n_q;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    stack_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_idx == SPW'(i)) stack_top = stack_q[i];
    end
  end

  always_comb begin
    upc_d = upc_inc;
    sp_d  = sp_q;
    err_d = err_q;
    z_d   = z_q;
    n_d   = n_q;
    push  = 1'b0;
    case (bus.na_sel)
      NA_SEQ:  upc_d = upc_inc;
      NA_JUMP: upc_d = bus.target;
      NA_COND: upc_d = cond ? bus.target : upc_inc;
      NA_MAP:  upc_d = map_addr;
      NA_CALL: begin
        upc_d = bus.target;
        if (sp_q < SP_FULL) begin
          push = 1'b1;
          sp_d = sp_q + SPW'(1);
        end else begin
          err_d = 1'b1;
        end
      end
      NA_RET: begin
        if (sp_q != '0) begin
          upc_d = stack_top;
          sp_d  = top_idx;
        end else begin
          upc_d = FETCH_ADDR;
          err_d = 1'b1;
        end
      end
      NA_FETCH: upc_d = FETCH_ADDR;
      default:  upc_d = upc_inc;
    endcase
    if (bus.fl_ld) begin
      z_d = bus.z_in;
      n_d = bus.n_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upc_q <= FETCH_ADDR;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else if (!bus.stall) begin
      upc_q <= upc_d;
      z_q   <= z_d;
      n_q   <= n_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack entries carry no reset; only the occupancy count does.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stack
      always_ff @(posedge clk) begin
        if (rst_n && !bus.stall && push && (sp_q == SPW'(gi))) begin
          stack_q[gi] <= upc_inc;
        end
      end
    end
  endgenerate

  assign bus.upc = upc_q;
  assign bus.z_q = z_q;
  assign bus.n_q = n_q;
  assign bus.sp  = sp_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: one task per feature, inline checks,
// expected values computed by hand from the next-address rules.
module tb_micro_sequencer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  micro_sequencer_if #(.AW(8), .OPW(4), .DEPTH(4)) bus ();

  micro_sequencer #(
    .AW(8), .OPW(4), .DEPTH(4), .MAP_BASE(8'h40), .FETCH_ADDR(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one microinstruction for one clock, then sample 1 time unit after the edge.
  task automatic step(input logic [2:0] na, input logic [2:0] bsel, input logic [7:0] tgt,
                      input logic [3:0] op, input logic fl, input logic z, input logic n,
                      input logic st);
    bus.na_sel = na;
    bus.bs     = bsel;
    bus.target = tgt;
    bus.opcode = op;
    bus.fl_ld  = fl;
    bus.z_in   = z;
    bus.n_in   = n;
    bus.stall  = st;
    @(posedge clk);
    #1;
    $display("step rst_n=%b na=%0d bs=%0d tgt=%h op=%h fl=%b st=%b -> upc=%h z=%b n=%b sp=%0d err=%b",
             rst_n, na, bsel, tgt, op, fl, st, bus.upc, bus.z_q, bus.n_q, bus.sp, bus.err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(3'd0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3'd0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'd0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h00) begin bad++; $display("FAIL reset_upc got=%h exp=00", bus.upc); end
    total++; if (bus.z_q !== 1'b0 || bus.n_q !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", bus.z_q, bus.n_q); end
    total++; if (bus.sp !== 3'd0) begin bad++; $display("FAIL reset_sp got=%0d exp=0", bus.sp); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(3'd0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.upc !== 8'(i)) begin bad++; $display("FAIL seq_%0d got=%h exp=%h", i, bus.upc, 8'(i)); end
    end
    // Build up flags and stack, then reset mid-routine.
    step(3'd0, 3'd0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(3'd4, 3'd0, 8'h20, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h20 || bus.sp !== 3'd1) begin bad++; $display("FAIL pre_reset_call upc=%h sp=%0d exp=20/1", bus.upc, bus.sp); end
    rst_n = 1'b0;
    step(3'd4, 3'd0, 8'h77, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
    total++; if (bus.upc !== 8'h00) begin bad++; $display("FAIL midreset_upc got=%h exp=00", bus.upc); end
    total++; if (bus.sp !== 3'd0) begin bad++; $display("FAIL midreset_sp got=%0d exp=0", bus.sp); end
    total++; if (bus.z_q !== 1'b0 || bus.n_q !== 1'b0) begin bad++; $display("FAIL midreset_flags got=%b%b exp=00", bus.z_q, bus.n_q); end
  endtask

  task automatic test_cond();
    do_reset();
    step(3'd0, 3'd0, 8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    total++; if (bus.z_q !== 1'b1 || bus.n_q !== 1'b0) begin bad++; $display("FAIL flag_load got=%b%b exp=10", bus.z_q, bus.n_q); end
    step(3'd2, 3'd0, 8'h20, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h20) begin bad++; $display("FAIL cond_eq got=%h exp=20", bus.upc); end
    step(3'd2, 3'd1, 8'h30, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h21) begin bad++; $display("FAIL cond_ne got=%h exp=21", bus.upc); end
    step(3'd2, 3'd2, 8'h30, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h30) begin bad++; $display("FAIL cond_gez got=%h exp=30", bus.upc); end
    step(3'd2, 3'd3, 8'h60, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h31) begin bad++; $display("FAIL cond_ltz got=%h exp=31", bus.upc); end
    step(3'd2, 3'd4, 8'h60, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h32) begin bad++; $display("FAIL cond_never got=%h exp=32", bus.upc); end
    // Same-cycle load: branch sees old Z=1, then flags become Z=0 N=1.
    step(3'd2, 3'd0, 8'h50, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (bus.upc !== 8'h50) begin bad++; $display("FAIL cond_oldflag got=%h exp=50", bus.upc); end
    total++; if (bus.z_q !== 1'b0 || bus.n_q !== 1'b1) begin bad++; $display("FAIL flag_reload got=%b%b exp=01", bus.z_q, bus.n_q); end
    step(3'd2, 3'd0, 8'h70, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h51) begin bad++; $display("FAIL cond_newflag_eq got=%h exp=51", bus.upc); end
    step(3'd2, 3'd3, 8'h70, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h70) begin bad++; $display("FAIL cond_newflag_ltz got=%h exp=70", bus.upc); end
  endtask

  task automatic test_map();
    step(3'd3, 3'd0, 8'h00, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h54) begin bad++; $display("FAIL map_5 got=%h exp=54", bus.upc); end
    step(3'd3, 3'd0, 8'h00, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h7C) begin bad++; $display("FAIL map_f got=%h exp=7c", bus.upc); end
    step(3'd3, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h40) begin bad++; $display("FAIL map_0 got=%h exp=40", bus.upc); end
  endtask

  task automatic test_calls();
    logic [7:0] tgts [4];
    logic [7:0] rets [4];
    tgts = '{8'h30, 8'h50, 8'h70, 8'h90};
    rets = '{8'h71, 8'h51, 8'h31, 8'h11};
    do_reset();
    step(3'd1, 3'd0, 8'h10, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h10) begin bad++; $display("FAIL jump got=%h exp=10", bus.upc); end
    for (int i = 0; i < 4; i++) begin
      step(3'd4, 3'd0, tgts[i], 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.upc !== tgts[i] || bus.sp !== 3'(i + 1)) begin
        bad++; $display("FAIL call_%0d upc=%h sp=%0d exp=%h/%0d", i, bus.upc, bus.sp, tgts[i], i + 1);
      end
    end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL call_full_err got=%b exp=0", bus.err); end
    step(3'd4, 3'd0, 8'hA0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'hA0 || bus.sp !== 3'd4 || bus.err !== 1'b1) begin
      bad++; $display("FAIL call_overflow upc=%h sp=%0d err=%b exp=a0/4/1", bus.upc, bus.sp, bus.err);
    end
    for (int i = 0; i < 4; i++) begin
      step(3'd5, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (bus.upc !== rets[i] || bus.sp !== 3'(3 - i)) begin
        bad++; $display("FAIL ret_%0d upc=%h sp=%0d exp=%h/%0d", i, bus.upc, bus.sp, rets[i], 3 - i);
      end
    end
    step(3'd5, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h00 || bus.sp !== 3'd0 || bus.err !== 1'b1) begin
      bad++; $display("FAIL ret_underflow upc=%h sp=%0d err=%b exp=00/0/1", bus.upc, bus.sp, bus.err);
    end
  endtask

  task automatic test_stall_wrap();
    do_reset();
    step(3'd1, 3'd0, 8'h22, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(3'd4, 3'd0, 8'h80, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
      total++; if (bus.upc !== 8'h22 || bus.sp !== 3'd0 || bus.z_q !== 1'b0 || bus.n_q !== 1'b0) begin
        bad++; $display("FAIL stall_%0d upc=%h sp=%0d zn=%b%b exp=22/0/00", i, bus.upc, bus.sp, bus.z_q, bus.n_q);
      end
    end
    step(3'd5, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (bus.upc !== 8'h22 || bus.err !== 1'b0) begin
      bad++; $display("FAIL stall_ret upc=%h err=%b exp=22/0", bus.upc, bus.err);
    end
    step(3'd0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h23) begin bad++; $display("FAIL unstall got=%h exp=23", bus.upc); end
    step(3'd1, 3'd0, 8'hFF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'd0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h00) begin bad++; $display("FAIL wrap got=%h exp=00", bus.upc); end
    step(3'd7, 3'd0, 8'h99, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h01) begin bad++; $display("FAIL na7_seq got=%h exp=01", bus.upc); end
    step(3'd6, 3'd0, 8'h99, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h00) begin bad++; $display("FAIL fetch got=%h exp=00", bus.upc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(3'd1, 3'd0, 8'h08, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'd4, 3'd0, 8'h40, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h40 || bus.sp !== 3'd1) begin
      bad++; $display("FAIL b2b_call upc=%h sp=%0d exp=40/1", bus.upc, bus.sp);
    end
    step(3'd5, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.upc !== 8'h09 || bus.sp !== 3'd0 || bus.err !== 1'b0) begin
      bad++; $display("FAIL b2b_ret upc=%h sp=%0d err=%b exp=09/0/0", bus.upc, bus.sp, bus.err);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    bus.stall  = 1'b0;
    bus.na_sel = 3'd0;
    bus.bs     = 3'd0;
    bus.target = 8'h00;
    bus.opcode = 4'h0;
    bus.fl_ld  = 1'b0;
    bus.z_in   = 1'b0;
    bus.n_in   = 1'b0;
    test_reset();
    test_cond();
    test_map();
    test_calls();
    test_stall_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the lab CPU control unit. Holds the control-store address register (uPC) and, each cycle, picks the next microaddress from the current microinstruction's next-address field. Choices are sequential, jump, conditional branch on latched Z/N flags, opcode dispatch, subroutine call, or return. It drives the control-store address and owns the condition-flag register and a small return-address stack.

## Interface
- AW, 8: microaddress width
- OPW, 4: opcode width
- DEPTH, 4: return-stack depth (entries, ≥1)
- MAP_BASE, 8'h40: dispatch table base address
- FETCH_ADDR, 0: microaddress of the fetch routine; also the reset address

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  1 = hold all state this cycle
- na_sel  in  3  next-address mode of the current microinstruction
- bs  in  3  branch select
- target  in  AW  branch/jump/call target
- opcode  in  OPW  opcode from the instruction register
- fl_ld  in  1  latch z_in/n_in into the flags
- z_in  in  1  ALU zero result
- n_in  in  1  ALU negative result
- upc  out  AW  current microaddress (registered)
- z_q  out  1  latched Z flag
- n_q  out  1  latched N flag
- sp  out  $clog2(DEPTH+1)  stack occupancy
- err  out  1  sticky stack fault

## Operation
Branch condition (combinational, from latched flags only):
- bs=000 EQ: z_q
- bs=001 NE: ~z_q
- bs=010 GEZ: ~n_q
- bs=011 LTZ: n_q
- bs=100..111: 0 (never)

Next-address modes (na_sel). Arithmetic is modulo 2^AW, so upc+1 wraps FF→00.
- 000 SEQ: upc+1
- 001 JUMP: target
- 010 COND: target if cond, else upc+1
- 011 MAP: (MAP_BASE + opcode*4) mod 2^AW. Default is 40 + 4·op.
- 100 CALL:
  - if sp<DEPTH: push upc+1, sp+1.
  - if sp==DEPTH: push dropped, sp unchanged, err←1.
  - In both cases the next address is target.
- 101 RET:
  - if sp>0: next = top, sp−1.
  - if sp==0: next = FETCH_ADDR, err←1.
- 110 FETCH: FETCH_ADDR
- 111: treated as SEQ

Flags:
- If fl_ld=1 and stall=0, then z_q←z_in and n_q←n_in.
- When fl_ld and COND occur in the same cycle, COND uses the old flags.

Stack: LIFO of AW-bit entries. The entries themselves are not reset; only sp is reset.

Stall: when stall=1, upc, flags, stack, sp and err all hold. The inputs are ignored.

Reset has priority over stall and over every other input.

## Timing
- Reset (rst_n=0 at an edge) clears state on that edge, including mid-routine or with a non-empty stack:
  - upc=FETCH_ADDR
  - z_q=0, n_q=0
  - sp=0
  - err=0
- Latency is one cycle: the microinstruction at upc in cycle k determines upc in cycle k+1. There is no bubble on a taken branch.
- A flag latched in cycle k is visible to COND in cycle k+1.
- A CALL in cycle k makes the return address readable by a RET in cycle k+1 (back-to-back CALL/RET is legal).
- err rises on the edge that ends the faulting cycle. It stays high until reset.
- All outputs are registered. There is no combinational input-to-output path.

## Test plan
- Reset then 3 SEQ cycles:
  - upc = 00, 01, 02, 03.
  - Assert rst_n=0 mid-sequence → upc=00 on the next edge, sp=0, flags 0.
- Flags and COND:
  - fl_ld with z_in=1, n_in=0, then COND with bs=000 and target=0x20 → upc=0x20.
  - Same with bs=001 → upc=prev+1.
  - bs=100 → never taken.
  - fl_ld and COND in the same cycle use the old flags.
- MAP:
  - opcode=4'h5 → upc=0x54.
  - opcode=4'hF → 0x7C.
- Nested CALLs:
  - 4 nested CALLs from 0x10, 0x30, 0x50, 0x70 (targets 0x30, 0x50, 0x70, 0x90) → sp=4, err=0.
  - A 5th CALL → jumps, sp=4, err=1.
  - 4 RETs → upc 0x71, 0x51, 0x31, 0x11.
  - A 5th RET → upc=00, err stays 1.
- Stall and wrap:
  - stall=1 for 3 cycles during a CALL with fl_ld=1 → no change to upc, sp, or flags.
  - SEQ at upc=0xFF → 0x00.
- Back-to-back CALL at 0x08 to 0x40, then RET at 0x40 → upc=0x09, sp=0.
